// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache: zero-stall hits, single-block refill
// from instruction memory on a miss while busywait holds the PC stage.
module icache_controller #(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  output logic [31:0]           instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [ADDR_BITS-5:0]  mem_address,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_busywait
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 4;
  localparam int BLK_BITS = ADDR_BITS - 4;
  localparam int LINES    = 2 ** INDEX_BITS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                state, next_state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_array  [LINES];
  logic [127:0]          data_array [LINES];
  logic [BLK_BITS-1:0]   blk_addr;

  logic [1:0]            pc_word;
  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic                  hit;
  logic                  refill;
  logic [INDEX_BITS-1:0] blk_index;
  logic [TAG_BITS-1:0]   blk_tag;
  logic                  unused_pc;

  assign pc_word   = pc[3:2];
  assign pc_index  = pc[INDEX_BITS+3:4];
  assign pc_tag    = pc[ADDR_BITS-1:INDEX_BITS+4];
  // Byte offset and high PC bits are intentionally ignored (memory aliases).
  assign unused_pc = ^{pc[31:ADDR_BITS], pc[1:0]};

  assign hit       = valid[pc_index] && (tag_array[pc_index] == pc_tag);
  assign refill    = (state == FETCH) && !mem_busywait;
  assign blk_index = blk_addr[INDEX_BITS-1:0];
  assign blk_tag   = blk_addr[BLK_BITS-1:INDEX_BITS];
  assign mem_address = blk_addr;

  // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    busywait    = 1'b0;
    instruction = '0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          instruction = data_array[pc_index][32*pc_word +: 32];
        end else begin
          busywait   = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        busywait = 1'b1;
        if (!mem_busywait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // The PC stage must not see a stall or stale data while reset is held.
    if (reset) begin
      busywait    = 1'b0;
      instruction = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_read <= 1'b0;
      blk_addr <= '0;
      valid    <= '0;
    end else begin
      state    <= next_state;
      mem_read <= (next_state == FETCH);
      if (state == IDLE && !hit) blk_addr <= {pc_tag, pc_index};
      if (refill) valid[blk_index] <= 1'b1;
    end
  end

  // NOTE: tag and data storage carry no reset; the valid bits alone make uninitialised lines unusable.
  always_ff @(posedge clk) begin
    if (refill) begin
      tag_array[blk_index]  <= blk_tag;
      data_array[blk_index] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Directed self-checking bench for icache_controller with a behavioural
// instruction memory whose read latency is set per step.
module tb_icache_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  pc;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int vectors     = 0;
  int miscompares = 0;
  int lat         = 5;
  int cnt         = 0;

  icache_controller #(.ADDR_BITS(10), .INDEX_BITS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clk = ~clk;

  // Word k of block b holds 0x0A + k + (b << 8); block 0 is D_C_B_A.
  function automatic logic [31:0] word(input logic [5:0] b, input int k);
    return 32'h0A + k + {18'd0, b, 8'd0};
  endfunction

  function automatic logic [127:0] blk_data(input logic [5:0] b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = word(b, k);
    return r;
  endfunction

  // Memory answers on the lat-th cycle of a read request; lat = 0 means never busy.
  initial begin
    mem_busywait = 1'b1;
    mem_readdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read) cnt++;
      else cnt = 0;
      mem_busywait = (cnt < lat);
      mem_readdata = blk_data(mem_address);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the miss cycle; leaves in the first hit cycle after the refill.
  task automatic run_miss(input string tag, input logic [5:0] addr, input int nfetch);
    int n;
    check({tag, "_miss_busywait"}, {31'd0, busywait}, 32'd1);
    check({tag, "_miss_instr"}, instruction, 32'd0);
    check({tag, "_miss_memread"}, {31'd0, mem_read}, 32'd0);
    tick();
    check({tag, "_fetch_memread"}, {31'd0, mem_read}, 32'd1);
    check({tag, "_fetch_addr"}, {26'd0, mem_address}, {26'd0, addr});
    check({tag, "_fetch_busywait"}, {31'd0, busywait}, 32'd1);
    n = 1;
    while (busywait && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_fetch_cycles"}, n - 1, nfetch);
    check({tag, "_done_memread"}, {31'd0, mem_read}, 32'd0);
  endtask

  initial begin
    // 1: reset state, cold miss to block 0 with 5-cycle memory
    reset = 1'b1;
    pc    = 32'h0;
    lat   = 5;
    tick();
    tick();
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_memread", {31'd0, mem_read}, 32'd0);
    check("rst_addr", {26'd0, mem_address}, 32'd0);
    reset = 1'b0;
    #1;
    run_miss("t1", 6'h00, 5);
    check("t1_instr", instruction, 32'h0000000A);

    // 2: remaining words of the block hit with no stall
    for (int k = 1; k < 4; k++) begin
      pc = 32'(4 * k);
      #1;
      check("t2_instr", instruction, word(6'h00, k));
      check("t2_busywait", {31'd0, busywait}, 32'd0);
      check("t2_memread", {31'd0, mem_read}, 32'd0);
      tick();
    end

    // 3: conflict eviction on index 0, then re-miss on the evicted block
    lat = 2;
    pc  = 32'h80;
    #1;
    run_miss("t3a", 6'h08, 2);
    check("t3a_instr", instruction, word(6'h08, 0));
    pc = 32'h0;
    #1;
    run_miss("t3b", 6'h00, 2);
    check("t3b_instr", instruction, 32'h0000000A);

    // 4: reset in the 3rd FETCH cycle clears valid bits and drops mem_read at once
    lat = 5;
    pc  = 32'h40;
    #1;
    check("t4_miss_busywait", {31'd0, busywait}, 32'd1);
    tick();
    check("t4_fetch_memread", {31'd0, mem_read}, 32'd1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t4_rst_memread", {31'd0, mem_read}, 32'd0);
    check("t4_rst_busywait", {31'd0, busywait}, 32'd0);
    check("t4_rst_instr", instruction, 32'd0);
    check("t4_rst_addr", {26'd0, mem_address}, 32'd0);
    tick();
    reset = 1'b0;
    lat   = 1;
    pc    = 32'h0;
    #1;
    run_miss("t4b", 6'h00, 1);
    check("t4b_instr", instruction, 32'h0000000A);
    pc = 32'h40;
    #1;
    run_miss("t4c", 6'h04, 1);
    check("t4c_instr", instruction, word(6'h04, 0));

    // 5: PC moves during FETCH; latched block still fills, then new PC misses
    lat = 4;
    pc  = 32'h10;
    #1;
    check("t5_miss_busywait", {31'd0, busywait}, 32'd1);
    tick();
    check("t5_fetch_memread", {31'd0, mem_read}, 32'd1);
    check("t5_fetch_addr", {26'd0, mem_address}, 32'd1);
    tick();
    pc = 32'h20;
    #1;
    check("t5_move_busywait", {31'd0, busywait}, 32'd1);
    check("t5_move_addr", {26'd0, mem_address}, 32'd1);
    tick();
    tick();
    tick();
    run_miss("t5b", 6'h02, 4);
    check("t5b_instr", instruction, word(6'h02, 0));
    pc = 32'h14;
    #1;
    check("t5_blk1_instr", instruction, word(6'h01, 1));
    check("t5_blk1_busywait", {31'd0, busywait}, 32'd0);

    // 6: zero-latency memory gives a 2-cycle stall; aliased and byte-offset PCs hit
    lat = 0;
    pc  = 32'h30;
    #1;
    run_miss("t6a", 6'h03, 1);
    check("t6a_instr", instruction, word(6'h03, 0));
    pc = 32'hFFFF_FC37;
    #1;
    check("t6_alias_instr", instruction, word(6'h03, 1));
    check("t6_alias_busywait", {31'd0, busywait}, 32'd0);
    pc = 32'hC0;
    #1;
    run_miss("t6b", 6'h0C, 1);
    check("t6b_instr", instruction, word(6'h0C, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
